// File: rtl/rv_step_sequencer_if.sv
// Handshake bundle between the control unit, the step sequencer and the
// storage-element enables of the multi-cycle RISC-V datapath.
interface rv_step_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             step_mode;
  logic [6:0]       opcode;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             take_target;
  logic             mem_ack;

  logic             fetch_en;
  logic             mem_rden;
  logic             mem_wren;
  logic             rf_wren;
  logic             pc_we;
  logic             pc_sel;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret;

  modport master (
    output start, step_mode, opcode, mem_read, mem_write, reg_write,
           take_target, mem_ack,
    input  fetch_en, mem_rden, mem_wren, rf_wren, pc_we, pc_sel, busy,
           halted, fault, state, cycle_cnt, instret
  );

  modport slave (
    input  start, step_mode, opcode, mem_read, mem_write, reg_write,
           take_target, mem_ack,
    output fetch_en, mem_rden, mem_wren, rf_wren, pc_we, pc_sel, busy,
           halted, fault, state, cycle_cnt, instret
  );
endinterface

// File: rtl/rv_step_sequencer.sv
// Single-clock multi-cycle sequencer: steps each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB and raises the per-stage storage enables.
module rv_step_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  rv_step_sequencer_if.slave  sif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_PAUSE  = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  // Wait counter value seen in the last MEM cycle allowed before timing out.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [7:0]       wait_cnt_q;
  logic             fault_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instret_q;

  logic             busy;
  logic             legal_op;
  logic             mem_timeout;

  always_comb begin
    legal_op = 1'b0;
    case (sif.opcode)
      7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
      7'b1100011, 7'b1101111, 7'b1100111: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  assign busy        = (state_q >= S_FETCH) && (state_q <= S_WB);
  // An ack arriving in the last allowed cycle takes priority over the timeout.
  assign mem_timeout = (state_q == S_MEM) && !sif.mem_ack && (wait_cnt_q == WAIT_LAST);

  // NOTE: combinational blocks assign every output a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sif.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = legal_op ? S_EXEC : S_HALT;
      S_EXEC:   state_d = (sif.mem_read || sif.mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        if (sif.mem_ack)  state_d = S_WB;
        else if (mem_timeout) state_d = S_HALT;
      end
      S_WB:     state_d = sif.step_mode ? S_PAUSE : S_FETCH;
      S_PAUSE:  if (sif.start) state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 8'd0;
      fault_q     <= 1'b0;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q <= state_d;

      // Clearing on the EXEC cycle means the first MEM cycle sees zero.
      if (state_q == S_EXEC)     wait_cnt_q <= 8'd0;
      else if (state_q == S_MEM) wait_cnt_q <= wait_cnt_q + 8'd1;

      if (mem_timeout) fault_q <= 1'b1;

      if (busy && (cycle_cnt_q != '1))
        cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
      if ((state_q == S_WB) && (instret_q != '1))
        instret_q <= instret_q + CNT_ONE;
    end
  end

  // Enables depend only on the state register and the control inputs.
  assign sif.fetch_en  = (state_q == S_FETCH);
  assign sif.mem_rden  = (state_q == S_MEM) && sif.mem_read;
  assign sif.mem_wren  = (state_q == S_MEM) && sif.mem_write;
  assign sif.rf_wren   = (state_q == S_WB)  && sif.reg_write;
  assign sif.pc_we     = (state_q == S_WB);
  assign sif.pc_sel    = (state_q == S_WB)  && sif.take_target;
  assign sif.busy      = busy;
  assign sif.halted    = (state_q == S_HALT);
  assign sif.fault     = fault_q;
  assign sif.state     = state_q;
  assign sif.cycle_cnt = cycle_cnt_q;
  assign sif.instret   = instret_q;

endmodule

// File: tb/tb_rv_step_sequencer.sv
// Self-checking bench for rv_step_sequencer: directed scenarios plus a random
// program, checked cycle by cycle against an instruction-level reference.
module tb_rv_step_sequencer;

  localparam int TO   = 3;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_PAUSE  = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_step_sequencer_if #(.CNT_W(CW)) sif ();

  rv_step_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int    total = 0;
  int    bad   = 0;
  int    exp_cyc;
  int    exp_ret;
  bit    exp_fault;
  string phase = "init";

  logic [6:0] legal_ops [7] = '{OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s/%s t=%0t: got %0h expected %0h", phase, tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Compare every output with what the expected state implies, then account
  // for the cycle in the instruction-level counters.
  task automatic chk(input logic [2:0] s);
    bit is_busy;
    is_busy = (s >= ST_FETCH) && (s <= ST_WB);
    check("state",     32'(sif.state),     32'(s));
    check("fetch_en",  32'(sif.fetch_en),  32'(s == ST_FETCH));
    check("mem_rden",  32'(sif.mem_rden),  32'((s == ST_MEM) && sif.mem_read));
    check("mem_wren",  32'(sif.mem_wren),  32'((s == ST_MEM) && sif.mem_write));
    check("rf_wren",   32'(sif.rf_wren),   32'((s == ST_WB) && sif.reg_write));
    check("pc_we",     32'(sif.pc_we),     32'(s == ST_WB));
    check("pc_sel",    32'(sif.pc_sel),    32'((s == ST_WB) && sif.take_target));
    check("busy",      32'(sif.busy),      32'(is_busy));
    check("halted",    32'(sif.halted),    32'(s == ST_HALT));
    check("fault",     32'(sif.fault),     32'(exp_fault));
    check("cycle_cnt", 32'(sif.cycle_cnt), 32'(sat(exp_cyc)));
    check("instret",   32'(sif.instret),   32'(sat(exp_ret)));
    if (is_busy) exp_cyc++;
    if (s == ST_WB) exp_ret++;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Called at a negedge while in FETCH; returns at the negedge after WB, or
  // at the first HALT negedge for an illegal opcode or a MEM timeout.
  // lat = MEM cycle carrying mem_ack (0 = never).
  task automatic run_instr(input logic [6:0] op, input bit mr, input bit mw,
                           input bit rw, input bit tt, input int lat);
    bit legal;
    legal = op inside {OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR};
    sif.opcode      = op;
    sif.mem_read    = mr;
    sif.mem_write   = mw;
    sif.reg_write   = rw;
    sif.take_target = tt;
    sif.mem_ack     = 1'b0;
    chk(ST_FETCH);  next();
    chk(ST_DECODE); next();
    if (!legal) begin
      chk(ST_HALT);
      return;
    end
    chk(ST_EXEC); next();
    if (mr || mw) begin
      for (int k = 1; k <= TO; k++) begin
        sif.mem_ack = (k == lat);
        chk(ST_MEM);
        next();
        if (k == lat) break;
        if (k == TO) begin
          exp_fault = 1'b1;
          chk(ST_HALT);
          return;
        end
      end
      sif.mem_ack = 1'b0;
    end
    chk(ST_WB); next();
  endtask

  task automatic go_idle(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      sif.start = 1'b0; chk(ST_IDLE); next();
    end
    sif.start = 1'b1; chk(ST_IDLE); next();
  endtask

  task automatic pause_then_go(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      sif.start = 1'b0; chk(ST_PAUSE); next();
    end
    sif.start = 1'b1; chk(ST_PAUSE); next();
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      sif.start = 1'b1; next(); chk(ST_HALT);
    end
  endtask

  // Asserts reset off-edge, checks the immediate effect, releases at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cyc = 0; exp_ret = 0; exp_fault = 1'b0;
    chk(ST_IDLE);
    next();
    chk(ST_IDLE);
    rst_n = 1'b1;
  endtask

  initial begin
    sif.start = 1'b0; sif.step_mode = 1'b0; sif.opcode = 7'd0;
    sif.mem_read = 1'b0; sif.mem_write = 1'b0; sif.reg_write = 1'b0;
    sif.take_target = 1'b0; sif.mem_ack = 1'b0;
    exp_cyc = 0; exp_ret = 0; exp_fault = 1'b0;
    @(negedge clk);
    do_reset();

    phase = "prog_end";
    go_idle(3);
    run_instr(OP_I, 0, 0, 1, 0, 0);
    run_instr(OP_R, 0, 0, 1, 0, 0);
    run_instr(7'd0, 0, 0, 0, 0, 0);
    check("end_instret", 32'(sif.instret),   32'd2);
    check("end_cycles",  32'(sif.cycle_cnt), 32'd10);
    check("end_fault",   32'(sif.fault),     32'd0);
    halt_hold(3);

    phase = "mem_branch";
    do_reset();
    go_idle(1);
    run_instr(OP_S,    0, 1, 0, 0, 2);
    run_instr(OP_L,    1, 0, 1, 0, 2);
    check("swlw_instret", 32'(sif.instret), 32'd2);
    run_instr(OP_B,    0, 0, 0, 1, 0);
    run_instr(OP_B,    0, 0, 0, 0, 0);
    run_instr(OP_S,    0, 1, 0, 0, TO);
    run_instr(OP_JAL,  0, 0, 1, 1, 0);
    run_instr(OP_JALR, 0, 0, 1, 1, 0);
    check("mix_instret", 32'(sif.instret), 32'd7);

    phase = "timeout";
    run_instr(OP_L, 1, 0, 1, 0, 0);
    check("to_fault",  32'(sif.fault),  32'd1);
    check("to_halted", 32'(sif.halted), 32'd1);
    halt_hold(4);

    phase = "step";
    do_reset();
    sif.step_mode = 1'b1;
    go_idle(0);
    run_instr(OP_I, 0, 0, 1, 0, 0);
    pause_then_go(0);
    run_instr(OP_R, 0, 0, 1, 0, 0);
    pause_then_go(5);
    run_instr(OP_L, 1, 0, 1, 0, 1);
    check("step_cycles", 32'(sif.cycle_cnt), 32'd13);
    sif.step_mode = 1'b0;
    pause_then_go(0);

    phase = "reset_mem";
    sif.opcode = OP_L; sif.mem_read = 1'b1; sif.mem_write = 1'b0;
    sif.reg_write = 1'b1; sif.take_target = 1'b0; sif.mem_ack = 1'b0;
    chk(ST_FETCH);  next();
    chk(ST_DECODE); next();
    chk(ST_EXEC);   next();
    chk(ST_MEM);
    do_reset();
    sif.start = 1'b0;
    next();
    chk(ST_IDLE);

    phase = "random";
    do_reset();
    go_idle(0);
    for (int n = 0; n < 75; n++) begin
      logic [6:0] op;
      bit mr, mw, sm;
      op = legal_ops[$urandom_range(0, 6)];
      mr = $urandom_range(0, 2) == 0;
      mw = !mr && ($urandom_range(0, 2) == 0);
      sm = $urandom_range(0, 3) == 0;
      sif.step_mode = sm;
      sif.start     = 1'($urandom_range(0, 1));
      run_instr(op, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, TO));
      if (sm) pause_then_go($urandom_range(0, 2));
    end
    check("sat_instret", 32'(sif.instret),   32'(CMAX));
    check("sat_cycles",  32'(sif.cycle_cnt), 32'(CMAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_step_sequencer.md
# rv_step_sequencer

Multi-cycle sequencer for the RISC-V datapath. It replaces the three phase-shifted PLL clocks with a single clock plus per-stage enables. It steps each instruction through fetch, decode, execute, optional memory access and writeback, and raises the enables for the instruction ROM, data RAM, register file and PC register at the correct cycles. It sits between the control unit and the storage elements. It adds halt-on-illegal-opcode, a RAM acknowledge handshake with timeout, single-step mode, and cycle/retired-instruction counters.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEM cycles without mem_ack before a fault halt (range 1..255).
- CNT_W, 32: width of cycle_cnt and instret.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE or PAUSE; ignored in every other state.
- step_mode  in  1  when 1, the sequencer parks in PAUSE after each writeback.
- opcode  in  7  instr[6:0] from ROM q; valid from DECODE through WB.
- mem_read  in  1  MemRead from control_unit.
- mem_write  in  1  MemWrite from control_unit.
- reg_write  in  1  RegWrite from control_unit.
- take_target  in  1  datapath-resolved (Branch & to_branch) | JAL | JALR.
- mem_ack  in  1  RAM access complete, sampled in MEM.
- fetch_en  out  1  ROM clock enable, 1 in FETCH only.
- mem_rden  out  1  equals mem_read while in MEM.
- mem_wren  out  1  equals mem_write while in MEM.
- rf_wren  out  1  equals reg_write while in WB.
- pc_we  out  1  1 in WB only.
- pc_sel  out  1  equals take_target in WB (1 = target, 0 = PC+4); 0 otherwise.
- busy  out  1  1 in FETCH, DECODE, EXEC, MEM and WB.
- halted  out  1  1 in HALT.
- fault  out  1  sticky; set on MEM timeout.
- state  out  3  current state encoding.
- cycle_cnt  out  CNT_W  busy cycles elapsed.
- instret  out  CNT_W  instructions retired.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PAUSE=6, HALT=7.
- IDLE: on start → FETCH.
- FETCH: → DECODE unconditionally.
- DECODE: legal opcodes are 0110011, 0010011, 0100011, 0000011, 1100011, 1101111 and 1100111.
  - Legal opcode → EXEC.
  - Any other opcode → HALT with fault=0. This is a normal program end.
- EXEC: if mem_read | mem_write → MEM, else → WB.
- MEM: wait counter clears on entry and increments each MEM cycle.
  - mem_ack=1 → WB.
  - Counter reaches MEM_TIMEOUT with no ack → HALT, fault←1.
  - Ack in the same cycle as the timeout: ack wins, no fault.
- WB: rf_wren, pc_we and pc_sel are driven as listed under Interface; instret increments.
  - step_mode=1 → PAUSE, else → FETCH.
- PAUSE: on start → FETCH.
- HALT: absorbing. Only rst_n exits it.
- Enable outputs are decoded from the state register and the listed inputs only. No other logic may gate them.
- cycle_cnt increments on every cycle with busy=1.
- cycle_cnt and instret saturate at all-ones and never wrap.
- Counters hold their values in IDLE, PAUSE and HALT.

## Timing
- Reset (asynchronous, immediate) drives:
  - state=IDLE;
  - all enables, busy, halted and fault to 0;
  - counters and the wait counter to 0.
- Reset asserted mid-instruction aborts it with no rf_wren or pc_we pulse. Release restarts in IDLE.
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory instruction: 4 + n cycles, where n is the number of MEM cycles up to and including the ack cycle.
- start must be asserted ≥1 cycle. A held start in PAUSE advances exactly one instruction per visit.
- ROM q must be valid in the cycle after fetch_en. The opcode and control inputs must stay stable until WB completes.
- The PC register latches on the clk edge ending WB. The next FETCH presents the new PC.

## Test plan
- Reset then start, program ADDI, ADD, 0x00000000 → DECODE of the third word goes to HALT.
  - instret=2, cycle_cnt=10, fault=0.
- SW then LW, mem_ack on the 2nd MEM cycle → each spends 2 cycles in MEM.
  - mem_wren high 2 cycles, then mem_rden high 2 cycles.
  - rf_wren pulses only for LW. instret=2.
- BEQ taken (take_target=1) → pc_sel=1 during the WB pulse.
  - Not taken: pc_sel=0 with pc_we=1.
- mem_ack held low with MEM_TIMEOUT=3 → HALT after 3 MEM cycles, fault=1, halted=1.
  - A later start does not leave HALT.
- step_mode=1 with start held high → one instruction per FETCH..PAUSE visit.
  - start low for 5 cycles in PAUSE leaves cycle_cnt unchanged.
- rst_n asserted during MEM → all outputs 0 immediately, state=0, counters 0, no rf_wren pulse.
